// File: rtl/fe_mul_mac_seq.sv
// fe_mul_mac_seq
// Sequential schoolbook multiplier for 5-limb field elements.
// Each MAC cycle it drives a cycle index to the multiply schedule ROM.
// It then accumulates a[i]*b[j] into column i+j, one partial product per
// cycle, for exactly 25 cycles. After that it streams the 9 unreduced
// columns over a valid/ready interface. Timing does not depend on the data.
//
// Optional build macro: FE_MUL_ZEROIZE_EN
//   When defined, operands and accumulators are wiped in the same cycle
//   that column 8 is accepted, and col_data reads 0 whenever col_valid=0.
//   Handshake timing is the same with or without the macro.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_valid      operands offered (input)
//   in_ready      core is idle and can accept operands (output)
//   a_in, b_in    operands, 5 limbs of LIMB_W bits each, limb 0 in the LSBs
//   sched_k       cycle index sent to the schedule ROM
//   sched_i       limb index of A returned by the ROM (same cycle)
//   sched_j       limb index of B returned by the ROM (same cycle)
//   col_valid     column output valid
//   col_ready     downstream accepts the column
//   col_idx       column number, 0..8
//   col_data      column sum
//   col_last      high together with column 8
//   sched_err     sticky flag: the ROM returned an index > 4 during the
//                 current operation
`timescale 1ns/1ps

module fe_mul_mac_seq #(
  parameter int LIMB_W = 51,
  parameter int ACC_W  = 2*LIMB_W+3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5*LIMB_W-1:0] a_in,
  input  logic [5*LIMB_W-1:0] b_in,
  output logic [4:0]          sched_k,
  input  logic [2:0]          sched_i,
  input  logic [2:0]          sched_j,
  output logic                col_valid,
  input  logic                col_ready,
  output logic [3:0]          col_idx,
  output logic [ACC_W-1:0]    col_data,
  output logic                col_last,
  output logic                sched_err
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t              state;
  logic [4:0]          k;
  logic [3:0]          col_cnt;
  logic [5*LIMB_W-1:0] a_reg;
  logic [5*LIMB_W-1:0] b_reg;
  logic [ACC_W-1:0]    acc [9];

  logic                idx_ok;
  logic [2:0]          ai;
  logic [2:0]          bj;
  logic [LIMB_W-1:0]   a_limb;
  logic [LIMB_W-1:0]   b_limb;
  logic [2*LIMB_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [3:0]          col_sel;

  // An out-of-range index is forced to 0 for the limb select, so the part
  // select can never go out of range. The accumulate is then skipped.
  assign idx_ok   = (sched_i <= 3'd4) && (sched_j <= 3'd4);
  assign ai       = idx_ok ? sched_i : 3'd0;
  assign bj       = idx_ok ? sched_j : 3'd0;
  assign a_limb   = a_reg[ai*LIMB_W +: LIMB_W];
  assign b_limb   = b_reg[bj*LIMB_W +: LIMB_W];
  assign prod     = {{LIMB_W{1'b0}}, a_limb} * {{LIMB_W{1'b0}}, b_limb};
  assign prod_ext = {{(ACC_W-2*LIMB_W){1'b0}}, prod};
  assign col_sel  = {1'b0, ai} + {1'b0, bj};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      col_cnt   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sched_err <= 1'b0;
      for (int n = 0; n < 9; n++) acc[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            sched_err <= 1'b0;
            k         <= '0;
            for (int n = 0; n < 9; n++) acc[n] <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          if (idx_ok) acc[col_sel] <= acc[col_sel] + prod_ext;
          else        sched_err    <= 1'b1;
          if (k == 5'd24) begin
            k       <= '0;
            col_cnt <= '0;
            state   <= DRAIN;
          end else begin
            k <= k + 5'd1;
          end
        end
        DRAIN: begin
          if (col_ready) begin
            if (col_cnt == 4'd8) begin
              col_cnt <= '0;
              state   <= IDLE;
`ifdef FE_MUL_ZEROIZE_EN
              a_reg   <= '0;
              b_reg   <= '0;
              for (int n = 0; n < 9; n++) acc[n] <= '0;
`endif
            end else begin
              col_cnt <= col_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // k is held at 0 outside MAC, so sched_k needs no separate gating.
  assign sched_k   = k;
  assign in_ready  = (state == IDLE);
  assign col_valid = (state == DRAIN);
  assign col_idx   = col_cnt;
  assign col_last  = (state == DRAIN) && (col_cnt == 4'd8);

`ifdef FE_MUL_ZEROIZE_EN
  assign col_data = col_valid ? acc[col_cnt] : '0;
`else
  assign col_data = acc[col_cnt];
`endif

endmodule

// File: tb/tb_fe_mul_mac_seq.sv
`timescale 1ns/1ps

module tb_fe_mul_mac_seq;
  localparam int LIMB_W = 51;
  localparam int ACC_W  = 2*LIMB_W+3;

  typedef logic [ACC_W-1:0] col_t;
  typedef struct {
    logic [3:0] idx;
    col_t       data;
    logic       last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [5*LIMB_W-1:0] a_in, b_in;
  logic [4:0]          sched_k;
  logic [2:0]          sched_i, sched_j;
  logic                col_valid, col_ready;
  logic [3:0]          col_idx;
  col_t                col_data;
  logic                col_last;
  logic                sched_err;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic       bad_en;
  logic [4:0] bad_k;

  fe_mul_mac_seq #(.LIMB_W(LIMB_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sched_k(sched_k), .sched_i(sched_i),
    .sched_j(sched_j), .col_valid(col_valid), .col_ready(col_ready),
    .col_idx(col_idx), .col_data(col_data), .col_last(col_last),
    .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  // Schedule ROM stub: k -> (k/5, k%5); optionally a bad i at cycle bad_k.
  always_comb begin
    sched_i = 3'(sched_k / 5'd5);
    sched_j = 3'(sched_k % 5'd5);
    if (bad_en && sched_k == bad_k) sched_i = 3'd5;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted column and checks that
  // the outputs hold steady while the sink is stalled.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_idx;
  col_t       prev_data;
  logic       last_taken = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
    if (last_taken) chk("in_ready_after_last", in_ready, 1);
    last_taken = 1'b0;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && col_valid) begin
        chk("stall_idx_stable", col_idx, prev_idx);
        chk("stall_data_stable", col_data, prev_data);
      end
      if (col_valid && col_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_column: got idx %0d, expected no column", col_idx);
        end else begin
          e = sb.pop_front();
          chk("col_idx", col_idx, e.idx);
          chk("col_data", col_data, e.data);
          chk("col_last", col_last, e.last);
          last_taken = col_last;
        end
      end
      prev_stall = col_valid && !col_ready;
      prev_idx   = col_idx;
      prev_data  = col_data;
    end
  end

  task automatic issue(input logic [5*LIMB_W-1:0] a, input logic [5*LIMB_W-1:0] b,
                       input col_t ex[9], input bit push);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    if (push)
      for (int c = 0; c < 9; c++) sb.push_back('{4'(c), ex[c], (c == 8)});
    #1 in_valid = 1'b0;
  endtask

  // The accept happened at the edge just before this task starts.
  // Negedge n follows edge T+n-1, so sched_k should equal n-1, and the
  // first col_valid is expected at n=26 (just after edge T+25).
  task automatic mac_phase(input bit chk_sched, input bit pulse);
    int n;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("in_ready_in_mac", in_ready, 0);
        chk("sched_err_cleared", sched_err, 0);
      end
      if (chk_sched && n <= 25) chk("sched_k", sched_k, n-1);
      if (pulse && n == 5) begin in_valid = 1'b1; a_in = '1; end
      if (pulse && n == 6) in_valid = 1'b0;
      if (col_valid) break;
    end
    chk("first_col_valid_latency", n, 26);
  endtask

  task automatic wait_idle(input bit stall);
    int n;
    bit stalled;
    stalled = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (stall && !stalled && col_valid && col_ready && col_idx == 4'd1) begin
        stalled = 1'b1;
        @(posedge clk); #1 col_ready = 1'b0; in_valid = 1'b1; b_in = '0;
        @(negedge clk); chk("stall_at_idx2", col_idx, 2);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 col_ready = 1'b1;
      end
      if (sb.size() == 0 && in_ready && !col_valid) break;
    end
    chk("drain_done_in_time", (n < 200), 1);
  endtask

  logic [5*LIMB_W-1:0] v1a, v1b, ones, v7a, v7b;
  col_t m, lmax;
  col_t ex1[9], exm[9], exbad[9], ex7[9], zero9[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; col_ready = 1'b1; bad_en = 1'b0; bad_k = 5'd7;
    a_in = '0; b_in = '0;

    v1a  = 255'd1;
    v1b  = 255'd5;
    ones = '1;
    v7a  = (255'd2 << 51) | 255'd1;
    v7b  = (255'd4 << 204) | 255'd3;
    lmax = col_t'({51{1'b1}});
    m    = lmax * lmax;
    for (int c = 0; c < 9; c++) begin
      ex1[c]   = (c == 0) ? col_t'(5) : '0;
      exm[c]   = m * col_t'(((c < 8-c) ? c : 8-c) + 1);
      exbad[c] = exm[c];
      ex7[c]   = '0;
      zero9[c] = '0;
    end
    exbad[3] = m * col_t'(3);
    ex7[0] = col_t'(3); ex7[1] = col_t'(6); ex7[4] = col_t'(4); ex7[5] = col_t'(8);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_col_valid", col_valid, 0);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_col_data", col_data, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_sched_err", sched_err, 0);
    chk("rst_sched_k", sched_k, 0);
    @(posedge clk); #1 rst = 1'b0;

    // a0=1, b0=5
    issue(v1a, v1b, ex1, 1);
    mac_phase(1, 0);
    wait_idle(0);

    // all limbs max
    issue(ones, ones, exm, 1);
    mac_phase(0, 0);
    wait_idle(0);
`ifdef FE_MUL_ZEROIZE_EN
    chk("idle_a_reg", dut.a_reg, 0);
    chk("idle_b_reg", dut.b_reg, 0);
    chk("idle_acc0", dut.acc[0], 0);
    chk("idle_acc4", dut.acc[4], 0);
`else
    chk("idle_a_reg", dut.a_reg, ones);
    chk("idle_b_reg", dut.b_reg, ones);
    chk("idle_acc0", dut.acc[0], m);
    chk("idle_acc4", dut.acc[4], m * col_t'(5));
`endif

    // backpressure at idx 2, in_valid pulsed in MAC and DRAIN
    issue(ones, ones, exm, 1);
    mac_phase(0, 1);
    wait_idle(1);

    // bad ROM index at k=7 -> (1,2) skipped, column 3 loses one M
    bad_en = 1'b1;
    issue(ones, ones, exbad, 1);
    mac_phase(1, 0);
    chk("sched_err_set", sched_err, 1);
    wait_idle(0);
    chk("sched_err_sticky_idle", sched_err, 1);
    bad_en = 1'b0;

    // next accept clears sched_err (checked at n=1 in mac_phase)
    issue(v1a, v1b, ex1, 1);
    mac_phase(0, 0);
    wait_idle(0);

    // abort with reset at k=10
    bad_en = 1'b1;
    issue(ones, ones, exm, 0);
    begin
      bit found;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (sched_k == 5'd10) begin found = 1'b1; break; end
      end
      chk("reach_k10", found, 1);
    end
    chk("sched_err_before_abort", sched_err, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bad_en = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_col_valid", col_valid, 0);
    chk("abort_sched_err", sched_err, 0);
    chk("abort_sched_k", sched_k, 0);

    // fresh operation after abort
    issue(v7a, v7b, ex7, 1);
    mac_phase(0, 0);
    wait_idle(0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
